inst_mem_responder: RTL and testbench

Instruction-memory responder: the slave end of the `ReadIF` read interface that the fetch stage drives as a master. It holds a word-addressed instruction RAM with a side-band loader port. It answers each accepted fetch request with one `valid` pulse carrying the addressed word, after a configurable number of wait states. It sits between the fetch stage and the program storage; with `WAIT_CYCLES=0` it sustains one instruction per cycle.

---
 rtl/inst_mem_responder_if.sv | 11 +
 rtl/inst_mem_responder.sv | 104 ++++++++++
 tb/tb_inst_mem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/inst_mem_responder_if.sv
// ReadIF: fetch-side read channel. The master presents a byte address with avalid.
// The slave returns one data word with a valid strobe.
interface ReadIF;
    logic [31:0] addr;
    logic        avalid;
    logic [31:0] data;
    logic        valid;

    modport Master (output addr, output avalid, input data, input valid);
    modport Slave  (input addr, input avalid, output data, output valid);
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: a word-addressed RAM with a side-band loader port.
// Each accepted fetch gets one valid pulse after WAIT_CYCLES wait states.
module inst_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ReadIF.Slave                           bus,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data,
    output logic                           busy,
    output logic                           addr_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        lat_addr;
    logic [31:0]        mem [DEPTH_WORDS];

    logic [31:0]        cur_off;
    logic [31:0]        lat_off;
    logic               cur_ok;
    logic               lat_ok;
    logic [31:0]        cur_word;
    logic [31:0]        lat_word;

    // Decode both the live address (zero-wait path) and the latched one (wait path)
    always_comb begin
        cur_off  = bus.addr - BASE_ADDR;
        lat_off  = lat_addr - BASE_ADDR;
        cur_ok   = ({1'b0, cur_off} < LIMIT);
        lat_ok   = ({1'b0, lat_off} < LIMIT);
        cur_word = cur_ok ? mem[cur_off[AW+1:2]] : 32'h0;
        lat_word = lat_ok ? mem[lat_off[AW+1:2]] : 32'h0;
    end

    // Loader port; reads in the same cycle still see the old word (read-first)
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            bus.valid <= 1'b0;
            bus.data  <= '0;
            addr_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            addr_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.avalid) begin
                        if (WAIT_CYCLES == 0) begin
                            bus.valid <= 1'b1;
                            bus.data  <= cur_word;
                            addr_err  <= !cur_ok;
                        end else begin
                            lat_addr <= bus.addr;
                            cnt      <= CNT_W'(WAIT_CYCLES);
                            busy     <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A redirect abandons the pending fetch and restarts the latency
                    if (bus.avalid && (bus.addr != lat_addr)) begin
                        lat_addr <= bus.addr;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                    end else if (cnt == CNT_W'(1)) begin
                        bus.valid <= 1'b1;
                        bus.data  <= lat_word;
                        addr_err  <= !lat_ok;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: four instances cover zero-wait, 3-wait,
// 5-wait with async reset, and a non-zero base address.
module tb_inst_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rst5_n;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    logic busy0, err0, busy3, err3, busy5, err5, busyb, errb;

    int n_vec;
    int n_err;

    ReadIF b0 ();
    ReadIF b3 ();
    ReadIF b5 ();
    ReadIF bb ();

    inst_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy0), .addr_err(err0));

    inst_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy3), .addr_err(err3));

    inst_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .bus(b5), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy5), .addr_err(err5));

    inst_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) dutb (
        .clk(clk), .rst_n(rst_n), .bus(bb), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busyb), .addr_err(errb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst5_n = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        b0.addr = '0; b0.avalid = 1'b0;
        b3.addr = '0; b3.avalid = 1'b0;
        b5.addr = '0; b5.avalid = 1'b0;
        bb.addr = '0; bb.avalid = 1'b0;

        #12;
        chk("rst_valid0", 32'(b0.valid), 32'h0);
        chk("rst_data0",  b0.data,        32'h0);
        chk("rst_err0",   32'(err0),      32'h0);
        chk("rst_busy3",  32'(busy3),     32'h0);
        chk("rst_valid3", 32'(b3.valid),  32'h0);
        rst_n  = 1'b1;
        rst5_n = 1'b1;

        tick();
        load(10'd0,    32'h00000013);
        load(10'd1,    32'h00100093);
        load(10'd2,    32'h00200113);
        load(10'd3,    32'h00300193);
        load(10'd1023, 32'hDEADBEEF);

        // Zero-wait streaming: back-to-back responses
        b0.avalid = 1'b1; b0.addr = 32'd0;
        tick(); chk("n0_v0", 32'(b0.valid), 32'h1); chk("n0_d0", b0.data, 32'h00000013); chk("n0_e0", 32'(err0), 32'h0);
        b0.addr = 32'd4;
        tick(); chk("n0_v1", 32'(b0.valid), 32'h1); chk("n0_d1", b0.data, 32'h00100093);
        b0.addr = 32'd8;
        tick(); chk("n0_v2", 32'(b0.valid), 32'h1); chk("n0_d2", b0.data, 32'h00200113);
        b0.addr = 32'd12;
        tick(); chk("n0_v3", 32'(b0.valid), 32'h1); chk("n0_d3", b0.data, 32'h00300193); chk("n0_e3", 32'(err0), 32'h0);
        b0.avalid = 1'b0;
        tick(); chk("n0_vdrop", 32'(b0.valid), 32'h0); chk("n0_dhold", b0.data, 32'h00300193);

        // Three wait states, address held
        b3.avalid = 1'b1; b3.addr = 32'd8;
        tick(); chk("n3_busy_e0", 32'(busy3), 32'h1); chk("n3_v_e0", 32'(b3.valid), 32'h0);
        tick(); chk("n3_busy_e1", 32'(busy3), 32'h1); chk("n3_v_e1", 32'(b3.valid), 32'h0);
        tick(); chk("n3_busy_e2", 32'(busy3), 32'h1); chk("n3_v_e2", 32'(b3.valid), 32'h0);
        tick(); chk("n3_v_e3", 32'(b3.valid), 32'h1); chk("n3_d_e3", b3.data, 32'h00200113);
        chk("n3_busy_e3", 32'(busy3), 32'h0);
        b3.avalid = 1'b0;
        tick(); chk("n3_v_e4", 32'(b3.valid), 32'h0);

        // Redirect abort: 4 then 12 one cycle later
        b3.avalid = 1'b1; b3.addr = 32'd4;
        tick(); b3.addr = 32'd12;
        tick(); chk("ab_v_e1", 32'(b3.valid), 32'h0); chk("ab_busy_e1", 32'(busy3), 32'h1);
        tick(); chk("ab_v_e2", 32'(b3.valid), 32'h0);
        tick(); chk("ab_v_e3", 32'(b3.valid), 32'h0);
        tick(); chk("ab_v_e4", 32'(b3.valid), 32'h1); chk("ab_d_e4", b3.data, 32'h00300193);
        b3.avalid = 1'b0;
        tick(); chk("ab_v_e5", 32'(b3.valid), 32'h0); chk("ab_busy_e5", 32'(busy3), 32'h0);

        // Range checks with BASE_ADDR=0x1000
        bb.avalid = 1'b1; bb.addr = 32'h1FFC;
        tick(); chk("rg_top_v", 32'(bb.valid), 32'h1); chk("rg_top_d", bb.data, 32'hDEADBEEF); chk("rg_top_e", 32'(errb), 32'h0);
        bb.addr = 32'h0FFC;
        tick(); chk("rg_low_d", bb.data, 32'h0); chk("rg_low_e", 32'(errb), 32'h1);
        bb.addr = 32'h2000;
        tick(); chk("rg_high_d", bb.data, 32'h0); chk("rg_high_e", 32'(errb), 32'h1);
        bb.avalid = 1'b0;
        tick(); chk("rg_e_drop", 32'(errb), 32'h0);

        // Read/load collision on word 2
        load(10'd2, 32'hAAAA0000);
        b0.avalid = 1'b1; b0.addr = 32'd8;
        ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'h5555FFFF;
        tick(); chk("col_old", b0.data, 32'hAAAA0000);
        ld_en = 1'b0;
        tick(); chk("col_new", b0.data, 32'h5555FFFF);
        b0.avalid = 1'b0;
        tick();

        // Five wait states, then async reset mid-countdown
        b5.avalid = 1'b1; b5.addr = 32'd4;
        tick(); chk("n5_busy_e0", 32'(busy5), 32'h1);
        tick(); tick(); tick(); tick();
        chk("n5_v_e4", 32'(b5.valid), 32'h0);
        tick(); chk("n5_v_e5", 32'(b5.valid), 32'h1); chk("n5_d_e5", b5.data, 32'h00100093);
        b5.addr = 32'd8;
        tick(); chk("n5_busy_re", 32'(busy5), 32'h1);
        b5.avalid = 1'b0;
        tick();
        #3;
        rst5_n = 1'b0;
        #1;
        chk("ar_busy",  32'(busy5),    32'h0);
        chk("ar_valid", 32'(b5.valid), 32'h0);
        chk("ar_err",   32'(err5),     32'h0);
        chk("ar_data",  b5.data,       32'h0);
        #1;
        rst5_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (b5.valid === 1'b1) seen++;
        end
        chk("ar_no_stale", 32'(seen),  32'h0);
        chk("ar_busy_end", 32'(busy5), 32'h0);
        chk("ar_data_end", b5.data,    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
